// File: rtl/branch_predictor.sv
// Branch history table plus branch target buffer for the RV32I fetch stage.
// Zero-latency lookup, registered training, sequential table clear and perf counters.
module branch_predictor #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [XLEN-1:0]  pc_f,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,

    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,

    input  logic             clear,
    output logic             busy,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];

    logic [CNT_W-1:0] br_count_q;
    logic [CNT_W-1:0] mispred_count_q;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [1:0]       u_ctr_nxt;

    // Upper fetch-PC bits beyond the tag and the byte offset do not take part in lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+TAG_W+2], pc_f[1:0]};

    assign f_idx = pc_f[IDX_W+1:2];
    assign f_tag = pc_f[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    assign busy  = (state_q == StSweep);

    // Lookup reads the pre-update table, so same-cycle training is seen one cycle later.
    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = !busy && f_hit && ctr_q[f_idx][1];
        pred_target = pred_taken ? target_q[f_idx] : '0;
    end

    always_comb begin
        mispredict  = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : (upd_pc + XLEN'(4));
    end

    always_comb begin
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_ctr_nxt = ctr_q[u_idx];
        if (upd_taken) begin
            if (ctr_q[u_idx] != 2'b11) u_ctr_nxt = ctr_q[u_idx] + 2'd1;
        end else begin
            if (ctr_q[u_idx] != 2'b00) u_ctr_nxt = ctr_q[u_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clear) begin
                        state_q <= StSweep;
                        ptr_q   <= '0;
                    end
                end
                StSweep: begin
                    ptr_q <= ptr_q + IDX_W'(1);
                    if (ptr_q == LAST_IDX) state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // Training is dropped while sweeping, so the sweep never races an update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= 2'b00;
                target_q[i] <= '0;
            end
        end else if (state_q == StSweep) begin
            valid_q[ptr_q] <= 1'b0;
        end else if (upd_valid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= u_ctr_nxt;
                if (upd_taken) target_q[u_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                ctr_q[u_idx]    <= 2'b10;
                target_q[u_idx] <= upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (upd_valid)  br_count_q      <= br_count_q + CNT_W'(1);
            if (mispredict) mispred_count_q <= mispred_count_q + CNT_W'(1);
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch history table plus branch target buffer for the pipelined RV32I core.
- Sits beside the fetch PC register:
  - Supplies a same-cycle taken/target prediction for pc_f.
  - Is trained by the decode/execute stage once the branch resolves.
  - Flags mispredictions so the datapath replaces its unconditional flush-on-taken scheme with flush-on-mispredict only.
- Adds a sequential table-clear sweep and performance counters.

Parameters:
- ENTRIES, 64, number of table entries; power of two, minimum 4. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry.
- XLEN, 32, PC/target width.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- pc_f  input  XLEN  fetch PC to predict
- pred_taken  output  1  predicted taken for pc_f
- pred_target  output  XLEN  predicted target for pc_f (0 when pred_taken=0)
- upd_valid  input  1  resolved control-flow instruction in execute this cycle
- upd_pc  input  XLEN  PC of the resolved instruction
- upd_taken  input  1  actual outcome
- upd_target  input  XLEN  actual target (ALU result)
- upd_pred_taken  input  1  prediction carried down the pipe with that instruction
- upd_pred_target  input  XLEN  predicted target carried down the pipe
- mispredict  output  1  flush request, combinational
- redirect_pc  output  XLEN  correct next PC when mispredict=1
- clear  input  1  request full table invalidation
- busy  output  1  clear sweep in progress
- br_count  output  CNT_W  resolved updates counted
- mispred_count  output  CNT_W  mispredictions counted

Behaviour:
- Indexing:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, 2-bit saturating counter, target.
- Lookup (combinational, zero latency):
  - pred_taken = !busy & valid[idx] & tag match & ctr[1].
  - pred_target = stored target when pred_taken, else 0.
- Mispredict (combinational):
  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4 (XLEN wrap).
  - When mispredict=0, redirect_pc equals that same expression; it is don't-care for the datapath.
- Update (registered, at the clock edge; ignored while busy):
  - Hit (valid & tag match): ctr increments when taken, decrements when not taken, saturating at 2'b11 and 2'b00. Target is written only when taken.
  - Miss and taken: allocate (overwrite) with valid=1, new tag, ctr=2'b10, target=upd_target.
  - Miss and not taken: no change.
- Same-cycle read/write of the same index: lookup returns the pre-update contents; the new value is visible the next cycle.
- Clear FSM, states IDLE and SWEEP:
  - IDLE→SWEEP when clear=1; the sweep pointer is loaded with 0.
  - In SWEEP, valid[ptr] is cleared each cycle and ptr increments. After clearing ENTRIES-1, the FSM returns to IDLE.
  - busy=1 exactly ENTRIES cycles, starting the cycle after clear is sampled.
  - clear asserted during SWEEP is ignored.
  - During SWEEP, mispredict still evaluates normally; training is dropped.
- Counters:
  - br_count increments on each upd_valid, including during busy.
  - mispred_count increments on each mispredict.
  - Both wrap modulo 2^CNT_W.
- Reset (asynchronous, active-low):
  - All valid bits, counters, targets and tags reset to 0.
  - FSM resets to IDLE with ptr=0.
  - Outputs on reset: pred_taken=0, pred_target=0, busy=0, br_count=0, mispred_count=0. mispredict and redirect_pc follow their inputs combinationally.
  - Reset asserted mid-sweep aborts the sweep and returns to IDLE with the table cleared.
- The table is implemented in flops; no RAM macro or read latency.

Test Plan:
- Cold table, pc_f=0x40: pred_taken=0. Then upd_valid with upd_pc=0x40, upd_taken=1, upd_target=0x100, upd_pred_taken=0 → mispredict=1 and redirect_pc=0x100 that cycle. Next cycle, pc_f=0x40 gives pred_taken=1, pred_target=0x100, mispred_count=1.
- Counter saturation at 0x40:
  - Three more taken updates → ctr=11.
  - Then not-taken updates: after one, pred_taken stays 1; after two, pred_taken=0 and ctr=01.
  - A not-taken update with upd_pred_taken=1 → mispredict=1, redirect_pc=0x44.
- Aliasing: with ENTRIES=64, 0x40 and 0x140 share idx 16 with different tags. Taken update at 0x140 (target 0x200) → 0x40 misses (pred_taken=0); 0x140 predicts 0x200.
- Target change: hit entry predicted 0x100, actual taken to 0x180 → mispredict=1, redirect_pc=0x180. Next lookup gives 0x180.
- Clear: train 4 entries, pulse clear for 1 cycle → busy high for 64 cycles, updates during busy are ignored, all lookups afterwards give pred_taken=0. A second clear pulse mid-sweep does not extend busy.
- Reset mid-sweep: assert reset at sweep cycle 10 → busy=0 immediately, br_count=0 and mispred_count=0, all lookups not-taken after release.
